// File: rtl/sram_fill_responder_pkg.sv
// Shared types for the SRAM fill responder: the 32-bit register value
// and the state encoding of the fill sequencer.
package sram_fill_responder_pkg;

  typedef logic [31:0] regval_t;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    VALID,
    HOLD
  } fill_state_t;

  localparam int HALF_W = 16;

endpackage

// File: rtl/sram_fill_responder.sv
// Memory-side responder for cache line fills: serves each 32-bit word request
// with two 16-bit async SRAM reads (low half first) and pulses data_valid.
module sram_fill_responder
  import sram_fill_responder_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int SRAM_ADDR_W = 20
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   address_enable,
  input  regval_t                address,
  output logic                   data_valid,
  output regval_t                data,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  input  logic [HALF_W-1:0]      sram_dq,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n
);

  localparam int CNT_W = $clog2(WAIT_STATES + 1) + 1;

  fill_state_t            state;
  fill_state_t            next_state;
  logic [CNT_W-1:0]       wait_cnt;
  logic [29:0]            req_addr;
  logic [29:0]            next_req_addr;
  logic [HALF_W-1:0]      lo;
  logic                   entering;
  logic                   cnt_done;
  logic                   addr_changed;
  logic                   next_sel;
  logic                   next_valid;
  logic [SRAM_ADDR_W-1:0] next_sram_addr;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^address[1:0];
  assign addr_changed     = address[31:2] != req_addr;
  assign cnt_done         = wait_cnt == CNT_W'(WAIT_STATES);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort beats retarget, which beats completing the current half read.
  always_comb begin
    next_state    = state;
    next_req_addr = req_addr;
    entering      = 1'b0;
    case (state)
      IDLE: begin
        if (address_enable) begin
          next_req_addr = address[31:2];
          next_state    = LOW;
        end
      end
      LOW, HIGH: begin
        if (!address_enable) begin
          next_state = IDLE;
        end else if (addr_changed) begin
          next_req_addr = address[31:2];
          next_state    = LOW;
          entering      = 1'b1;
        end else if (cnt_done) begin
          next_state = (state == LOW) ? HIGH : VALID;
        end
      end
      VALID: begin
        next_state = HOLD;
      end
      HOLD: begin
        if (!address_enable) begin
          next_state = IDLE;
        end else if (addr_changed) begin
          next_req_addr = address[31:2];
          next_state    = LOW;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (next_state != state) begin
      entering = 1'b1;
    end
  end

  // Outputs are computed from the upcoming state so they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    next_sel       = (next_state == LOW) || (next_state == HIGH);
    next_valid     = next_state == VALID;
    next_sram_addr = sram_addr;
    if (next_sel) begin
      next_sram_addr = {next_req_addr[SRAM_ADDR_W-2:0], next_state == HIGH};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_valid <= 1'b0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      data_valid <= next_valid;
      sram_addr  <= next_sram_addr;
      sram_ce_n  <= !next_sel;
      sram_oe_n  <= !next_sel;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (entering) begin
      wait_cnt <= '0;
    end else if ((state == LOW) || (state == HIGH)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // dq is sampled on the edge that ends the last wait cycle of each half.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_addr <= '0;
      lo       <= '0;
      data     <= '0;
    end else begin
      req_addr <= next_req_addr;
      if ((state == LOW) && (next_state == HIGH)) begin
        lo <= sram_dq;
      end
      if ((state == HIGH) && (next_state == VALID)) begin
        data <= {sram_dq, lo};
      end
    end
  end

endmodule

// File: tb/tb_sram_fill_responder.sv
// Bench for sram_fill_responder: two instances (WAIT_STATES 2 and 0) share one
// request stream and are checked every cycle against a transaction-level model.
module tb_sram_fill_responder;
  import sram_fill_responder_pkg::*;

  localparam int WS_A = 2;
  localparam int WS_B = 0;

  localparam int PH_IDLE  = 0;
  localparam int PH_FILL  = 1;
  localparam int PH_VALID = 2;
  localparam int PH_HOLD  = 3;

  logic        clock;
  logic        reset_n;
  logic        address_enable;
  regval_t     address;
  logic        dv [2];
  regval_t     dat [2];
  logic [19:0] sa [2];
  logic [15:0] dq [2];
  logic        ce [2];
  logic        oe [2];

  int checks = 0;
  int errors = 0;

  int          m_phase [2];
  int          m_elapsed [2];
  logic [29:0] m_req [2];
  regval_t     m_data [2];

  function automatic logic [15:0] sram_half(input logic [19:0] a);
    if (a == 20'h80) return 16'hBEEF;
    if (a == 20'h81) return 16'hDEAD;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic regval_t word_at(input logic [29:0] wa);
    return {sram_half({wa[18:0], 1'b1}), sram_half({wa[18:0], 1'b0})};
  endfunction

  function automatic int ws_of(input int i);
    return (i == 0) ? WS_A : WS_B;
  endfunction

  assign dq[0] = sram_half(sa[0]);
  assign dq[1] = sram_half(sa[1]);

  sram_fill_responder #(.WAIT_STATES(WS_A), .SRAM_ADDR_W(20)) dut_a (
    .clock(clock), .reset_n(reset_n), .address_enable(address_enable), .address(address),
    .data_valid(dv[0]), .data(dat[0]), .sram_addr(sa[0]), .sram_dq(dq[0]),
    .sram_ce_n(ce[0]), .sram_oe_n(oe[0])
  );

  sram_fill_responder #(.WAIT_STATES(WS_B), .SRAM_ADDR_W(20)) dut_b (
    .clock(clock), .reset_n(reset_n), .address_enable(address_enable), .address(address),
    .data_valid(dv[1]), .data(dat[1]), .sram_addr(sa[1]), .sram_dq(dq[1]),
    .sram_ce_n(ce[1]), .sram_oe_n(oe[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // A fill is a run of 2*(ws+1) select cycles, low half then high half,
  // followed by one pulse cycle and then a hold until the request moves on.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_phase[i]   <= PH_IDLE;
        m_elapsed[i] <= 0;
        m_req[i]     <= '0;
        m_data[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (m_phase[i])
          PH_IDLE: if (address_enable) begin
            m_phase[i]   <= PH_FILL;
            m_elapsed[i] <= 0;
            m_req[i]     <= address[31:2];
          end
          PH_FILL: begin
            if (!address_enable) begin
              m_phase[i] <= PH_IDLE;
            end else if (address[31:2] != m_req[i]) begin
              m_req[i]     <= address[31:2];
              m_elapsed[i] <= 0;
            end else if (m_elapsed[i] == 2 * (ws_of(i) + 1) - 1) begin
              m_phase[i] <= PH_VALID;
              m_data[i]  <= word_at(m_req[i]);
            end else begin
              m_elapsed[i] <= m_elapsed[i] + 1;
            end
          end
          PH_VALID: m_phase[i] <= PH_HOLD;
          default: begin
            if (!address_enable) begin
              m_phase[i] <= PH_IDLE;
            end else if (address[31:2] != m_req[i]) begin
              m_phase[i]   <= PH_FILL;
              m_elapsed[i] <= 0;
              m_req[i]     <= address[31:2];
            end
          end
        endcase
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      check_output($sformatf("dv%0d", k), 32'(dv[k]), 32'(m_phase[k] == PH_VALID));
      check_output($sformatf("data%0d", k), dat[k], m_data[k]);
      check_output($sformatf("ce%0d", k), 32'(ce[k]), 32'(m_phase[k] != PH_FILL));
      check_output($sformatf("oe%0d", k), 32'(oe[k]), 32'(m_phase[k] != PH_FILL));
      if (m_phase[k] == PH_FILL) begin
        check_output($sformatf("addr%0d", k), 32'(sa[k]),
                     32'({m_req[k][18:0], m_elapsed[k] >= ws_of(k) + 1}));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_cycles(input int n);
    for (int c = 0; c < n; c++) next_cycle();
  endtask

  task automatic apply_stimulus(input logic en, input regval_t addr);
    address_enable = en;
    address        = addr;
  endtask

  // Literal checks land 1 time unit after the posedge+2 drive point.
  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    #1;
    check_output(name, act, exp);
  endtask

  initial begin
    reset_n = 1'b1;
    apply_stimulus(1'b0, 32'h0);
    #1 reset_n = 1'b0;
    pin("rst_dv", 32'(dv[0]), 32'h0);
    pin("rst_ce", 32'(ce[0]), 32'h1);
    pin("rst_data", dat[0], 32'h0);
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(2);

    $display("[TB] basic fill at 0x100");
    apply_stimulus(1'b1, 32'h100);
    next_cycle();
    pin("t1_addr_lo", 32'(sa[0]), 32'h80);
    pin("t1_ce_lo", 32'(ce[0]), 32'h0);
    wait_cycles(3);
    pin("t1_addr_hi", 32'(sa[0]), 32'h81);
    wait_cycles(2);
    pin("t1_dv_c6", 32'(dv[0]), 32'h0);
    next_cycle();
    pin("t1_dv_c7", 32'(dv[0]), 32'h1);
    pin("t1_data", dat[0], 32'hDEADBEEF);
    next_cycle();
    pin("t1_dv_c8", 32'(dv[0]), 32'h0);

    $display("[TB] hold then new word");
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      pin("t2_hold_dv", 32'(dv[0]), 32'h0);
      pin("t2_hold_ce", 32'(ce[0]), 32'h1);
    end
    apply_stimulus(1'b1, 32'h104);
    wait_cycles(7);
    pin("t2_dv", 32'(dv[0]), 32'h1);
    pin("t2_data", dat[0], 32'h5AD95AD8);

    $display("[TB] abort in LOW");
    apply_stimulus(1'b0, 32'h100);
    wait_cycles(2);
    apply_stimulus(1'b1, 32'h100);
    wait_cycles(2);
    apply_stimulus(1'b0, 32'h100);
    next_cycle();
    pin("t3_ce", 32'(ce[0]), 32'h1);
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      pin("t3_dv", 32'(dv[0]), 32'h0);
    end
    pin("t3_data", dat[0], 32'h5AD95AD8);

    $display("[TB] retarget in HIGH");
    apply_stimulus(1'b1, 32'h100);
    wait_cycles(5);
    apply_stimulus(1'b1, 32'h200);
    next_cycle();
    pin("t4_addr", 32'(sa[0]), 32'h100);
    wait_cycles(5);
    pin("t4_dv_early", 32'(dv[0]), 32'h0);
    next_cycle();
    pin("t4_dv", 32'(dv[0]), 32'h1);
    pin("t4_data", dat[0], 32'h5B5B5B5A);

    $display("[TB] back-to-back with zero wait states");
    apply_stimulus(1'b0, 32'h0);
    wait_cycles(2);
    apply_stimulus(1'b1, 32'h0);
    wait_cycles(2);
    pin("t5_dv_early", 32'(dv[1]), 32'h0);
    next_cycle();
    pin("t5_dv0", 32'(dv[1]), 32'h1);
    pin("t5_data0", dat[1], 32'h5A5B5A5A);
    next_cycle();
    apply_stimulus(1'b0, 32'h0);
    next_cycle();
    apply_stimulus(1'b1, 32'h4);
    wait_cycles(3);
    pin("t5_dv1", 32'(dv[1]), 32'h1);
    pin("t5_data1", dat[1], 32'h5A595A58);

    $display("[TB] reset during HIGH");
    apply_stimulus(1'b0, 32'h0);
    wait_cycles(2);
    apply_stimulus(1'b1, 32'h100);
    wait_cycles(4);
    #3 reset_n = 1'b0;
    pin("t6_dv", 32'(dv[0]), 32'h0);
    pin("t6_data", dat[0], 32'h0);
    pin("t6_addr", 32'(sa[0]), 32'h0);
    pin("t6_ce", 32'(ce[0]), 32'h1);
    pin("t6_oe", 32'(oe[0]), 32'h1);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    pin("t6_restart_ce", 32'(ce[0]), 32'h0);
    pin("t6_restart_addr", 32'(sa[0]), 32'h80);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        address_enable = !address_enable;
      end
      if ($urandom_range(0, 11) == 0) begin
        address = ($urandom & 32'hFFE0_0000) | (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'h3);
      end
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
      end
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
